// File: rtl/forward_round_engine.sv
// forward_round_engine
//   Iterative encrypt-direction cipher round engine. One 128-bit plaintext
//   block is accepted in IDLE and XORed with round key 0. The engine then
//   runs NUM_ROUNDS forward rounds, one per clock. Each round applies
//   SubBytes, ShiftRows, MixColumns and AddRoundKey. The ciphertext is then
//   held in DONE until the sink takes it.
//
//   Byte (r,c) of every 128-bit bus is bus[127-8*(4c+r) -: 8].
//
//   Parameters
//     NUM_ROUNDS : number of forward rounds after the initial key addition.
//                  Legal range is 1..15.
//
//   Ports
//     clk, rst   : rising-edge clock and synchronous active-high reset
//     in_valid   : plaintext on block_in is valid
//     in_ready   : engine can accept a block (IDLE only)
//     block_in   : plaintext block
//     key_round  : index of the round key needed this cycle
//     key        : round key for key_round, combinational from the key store
//     out_valid  : block_out holds a finished ciphertext
//     out_ready  : sink takes block_out
//     block_out  : registered ciphertext
//     busy       : high in RUN and DONE
//
//   Build option
//     ENC_LAST_ROUND_NOMIX_EN : when defined, the final round skips
//     MixColumns. This gives standard AES-128 at NUM_ROUNDS=10. When
//     undefined, every round is uniform, so each round is the exact inverse
//     of the decrypt-side reverse round.
module forward_round_engine #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] block_in,
  output logic [3:0]   key_round,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] block_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  // AES S-box; entry x sits at bits [(255-x)*8 +: 8]
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  // multiply by 02 in GF(2^8) modulo 0x11B
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // one MixColumns column, row 0 in the MSB byte
  function automatic logic [31:0] mixcol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  state_t       st, st_nx;
  logic [3:0]   rnd, rnd_nx;
  logic [127:0] blk, blk_nx;
  logic [127:0] out_q, out_nx;
  logic [127:0] sh, mixed, diff, rnd_res;
  logic         last;

  assign last = (rnd == LAST);

  // SubBytes fused with ShiftRows: output (r,c) takes input (r,(c+r)%4)
  always_comb begin
    sh = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sh[127 - 8*(4*c + r) -: 8] = sub(blk[127 - 8*(4*((c + r) % 4) + r) -: 8]);
  end

  always_comb begin
    mixed = '0;
    for (int unsigned c = 0; c < 4; c++)
      mixed[127 - 32*c -: 32] = mixcol(sh[127 - 32*c -: 32]);
  end

`ifdef ENC_LAST_ROUND_NOMIX_EN
  assign diff = last ? sh : mixed;
`else
  assign diff = mixed;
`endif

  assign rnd_res = diff ^ key;

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      rnd   <= '0;
      blk   <= '0;
      out_q <= '0;
    end else begin
      st    <= st_nx;
      rnd   <= rnd_nx;
      blk   <= blk_nx;
      out_q <= out_nx;
    end
  end

  always_comb begin
    st_nx     = st;
    rnd_nx    = rnd;
    blk_nx    = blk;
    out_nx    = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    key_round = '0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_nx = block_in ^ key;
          rnd_nx = 4'd1;
          st_nx  = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        key_round = rnd;
        blk_nx    = rnd_res;
        if (last) begin
          out_nx = rnd_res;
          rnd_nx = '0;
          st_nx  = DONE;
        end else begin
          rnd_nx = rnd + 4'd1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  assign block_out = out_q;

endmodule

// File: doc/forward_round_engine.md
# forward_round_engine

Iterative cipher-round engine for the encrypt direction: accepts one 128-bit plaintext block, applies an initial key addition and then NUM_ROUNDS forward rounds (substitute → diffusion → add round key), one round per clock, and returns the ciphertext block. It undoes exactly what the decrypt-side reverse round does (add round key → reverse diffusion → reverse substitute). It sits between the plaintext source and the ciphertext sink, with round keys supplied combinationally by the key store through a round-index request.

## Interface
- NUM_ROUNDS, 10, forward rounds after the initial key addition; legal range 1..15.
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  block_in is valid.
- in_ready  output  1  engine can accept a block (IDLE only).
- block_in  input  128  plaintext; byte (r,c) = block_in[127-8*(4c+r) -: 8].
- key_round  output  4  round index whose key is required this cycle.
- key  input  128  round key for key_round, same byte mapping, valid same cycle (combinational).
- out_valid  output  1  block_out holds a finished ciphertext.
- out_ready  input  1  sink takes block_out.
- block_out  output  128  ciphertext, registered, same byte mapping.
- busy  output  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE. Round counter rnd, 4 bits.
- IDLE: in_ready=1, key_round=0. On in_valid: state ← block_in ^ key, rnd ← 1, go to RUN.
- RUN: key_round=rnd. State ← AddRoundKey(Diffusion(Substitute(state)), key).
  - Substitute: AES S-box on all 16 bytes.
  - Diffusion: ShiftRows (row r rotated left by r) then MixColumns (GF(2^8), poly 0x11B, matrix 02 03 01 01 circulant).
  - If rnd == NUM_ROUNDS: block_out ← result, go to DONE; else rnd ← rnd+1.
- DONE: out_valid=1, block_out stable. On out_ready: go to IDLE.
- in_valid outside IDLE is ignored; in_ready is low there.
- Internal state register is not observable; block_out changes only on the RUN→DONE edge.
- Reset values: in_ready=1 after the reset cycle (state IDLE), out_valid=0, busy=0, key_round=0, block_out=0, rnd=0.
- Reset in RUN or DONE aborts the block; no partial result is ever output.

## Timing
- Accept at edge T (in_valid & in_ready) → RUN from T+1, rounds on edges T+1..T+NUM_ROUNDS → out_valid high from T+NUM_ROUNDS.
- Latency accept-to-out_valid: NUM_ROUNDS cycles. Occupancy: NUM_ROUNDS+1 cycles minimum per block.
- out_valid & out_ready at edge D → IDLE at D+1; in_ready high from D+1. No same-cycle output/accept overlap.
- out_ready held low: DONE held indefinitely, block_out and out_valid unchanged.
- key must settle within the same cycle key_round is presented; key_round is a decode of state and rnd only (no input dependency).
- Throughput at NUM_ROUNDS=10 with out_ready=1: one block per 12 cycles.

## Configuration
- ENC_LAST_ROUND_NOMIX_EN defined: the round with rnd == NUM_ROUNDS skips MixColumns (ShiftRows still applied); result is standard AES-128 at NUM_ROUNDS=10.
- Undefined: every round applies full diffusion, matching the uniform decrypt-side reverse round so the two directions invert each other round-for-round.

## Test plan
- Macro defined, NUM_ROUNDS=10, FIPS-197 schedule for key 2b7e151628aed2a6abf7158809cf4f3c, block_in 3243f6a8885a308d313198a2e0370734 → block_out 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept.
- Macro defined, all-zero key schedule of key 0, block_in 0 → block_out 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Macro undefined, random block and 11 random round keys → feeding block_out through 10 decrypt-side reverse rounds (keys in reverse order) plus final key XOR returns the original block.
- out_ready low for 20 cycles in DONE, in_valid pulsed meanwhile → block_out stable, out_valid held, in_ready 0, second block not accepted; accepted only the cycle after handshake.
- rst asserted at round 5 → next cycle out_valid=0, busy=0, block_out=0, key_round=0, in_ready=1; fresh block then completes correctly.
- key_round monitor over one block → sequence 0,1,2,…,10 on consecutive cycles, then 0 in DONE/IDLE.
